register_file_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the latch-based register file between NUM_REQ requesters.
- Issues at most one write per cycle, with registered write outputs, and drops writes to word 0.
- Forwards in-flight write data to both read ports, which hides the register file's sampled-wdata/latch write latency from readers.
- Sits directly between the datapath write sources and the register file.

---
 rtl/register_file_write_arbiter.sv | 93 +++++++++
 tb/tb_register_file_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_write_arbiter.sv
// register_file_write_arbiter: round-robin owner of the RF write port, with registered
// writes and forwarding of in-flight write data to both read ports.
module register_file_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DataWidth  = 16,
  parameter int FwdDepth   = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            hold_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DataWidth-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            rf_we_o,
  output logic [ADDR_WIDTH-1:0]           rf_waddr_o,
  output logic [DataWidth-1:0]            rf_wdata_o,
  input  logic [ADDR_WIDTH-1:0]           raddr_a_i,
  output logic [DataWidth-1:0]            rdata_a_o,
  input  logic [ADDR_WIDTH-1:0]           raddr_b_i,
  output logic [DataWidth-1:0]            rdata_b_o,
  input  logic [DataWidth-1:0]            rf_rdata_a_i,
  input  logic [DataWidth-1:0]            rf_rdata_b_i,
  output logic                            busy_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  logic [PW-1:0]          ptr_q, ptr_d, off, gnt_idx;
  logic [2*NUM_REQ-1:0]   dbl;
  logic [PW:0]            sum;
  logic                   gnt;
  logic [ADDR_WIDTH-1:0]  sel_addr, waddr_q, waddr_d, f1_addr_q, f1_addr_d;
  logic [DataWidth-1:0]   sel_data, wdata_q, wdata_d, f1_data_q, f1_data_d;
  logic                   we_q, we_d, f1_vld_q, f1_vld_d;
  // Rotate valids so the pointer sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    dbl = {req_valid_i, req_valid_i} >> ptr_q;
    gnt = rst_ni && !hold_i && |dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) off = dbl[i] ? PW'(i) : off;
    sum = {1'b0, ptr_q} + {1'b0, off};
    gnt_idx = (sum >= NR) ? PW'(sum - NR) : sum[PW-1:0];
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[k*DataWidth +: DataWidth];
      end
    end
    req_ready_o = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
    ptr_d = gnt ? ((gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    we_d = gnt && (sel_addr != '0);
    waddr_d = we_d ? sel_addr : waddr_q;
    wdata_d = we_d ? sel_data : wdata_q;
    f1_vld_d = (FwdDepth > 1) && we_q;
    f1_addr_d = we_q ? waddr_q : f1_addr_q;
    f1_data_d = we_q ? wdata_q : f1_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      f1_vld_q  <= 1'b0;
      f1_addr_q <= '0;
      f1_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      f1_vld_q  <= f1_vld_d;
      f1_addr_q <= f1_addr_d;
      f1_data_q <= f1_data_d;
    end
  end
  // The write being issued this cycle is entry 0; entry 1 is the one the RF just sampled.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? rf_rdata_a_i :
                (we_q && waddr_q == raddr_a_i) ? wdata_q :
                (f1_vld_q && f1_addr_q == raddr_a_i) ? f1_data_q : rf_rdata_a_i;
    rdata_b_o = (raddr_b_i == '0) ? rf_rdata_b_i :
                (we_q && waddr_q == raddr_b_i) ? wdata_q :
                (f1_vld_q && f1_addr_q == raddr_b_i) ? f1_data_q : rf_rdata_b_i;
  end
  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign busy_o     = we_q | f1_vld_q;
endmodule

// File: tb/tb_register_file_write_arbiter.sv
// tb_register_file_write_arbiter: directed checks of arbitration, issue timing,
// forwarding, address-0 drop, hold and asynchronous reset.
module tb_register_file_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  raddr_a, raddr_b;
  logic [15:0] rdata_a, rdata_b, rf_rdata_a, rf_rdata_b;
  logic        busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  register_file_write_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a), .rdata_a_o(rdata_a), .raddr_b_i(raddr_b), .rdata_b_o(rdata_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] a, input logic [15:0] d);
    req_valid[k] = 1'b1;
    req_addr[k*4 +: 4] = a;
    req_data[k*16 +: 16] = d;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    raddr_a = '0; raddr_b = '0; rf_rdata_a = '0; rf_rdata_b = '0;
    #1;
    chk("reset_we", 16'(rf_we), 16'h0);
    chk("reset_ready", 16'(req_ready), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_waddr", 16'(rf_waddr), 16'h0);
    step(); step();
    rst_n = 1'b1;
    // Round robin: all four valid continuously, addresses 1..4
    for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 16'hA000 + 16'(k));
    #1;
    chk("rr_ready0", 16'(req_ready), 16'h1);
    chk("rr_we0", 16'(rf_we), 16'h0);
    step();
    chk("rr_ready1", 16'(req_ready), 16'h2);
    chk("rr_we1", 16'(rf_we), 16'h1);
    chk("rr_waddr1", 16'(rf_waddr), 16'h1);
    chk("rr_wdata1", rf_wdata, 16'hA000);
    step();
    chk("rr_ready2", 16'(req_ready), 16'h4);
    chk("rr_waddr2", 16'(rf_waddr), 16'h2);
    step();
    chk("rr_ready3", 16'(req_ready), 16'h8);
    chk("rr_waddr3", 16'(rf_waddr), 16'h3);
    chk("rr_wdata3", rf_wdata, 16'hA002);
    step();
    chk("rr_ready4", 16'(req_ready), 16'h1);
    chk("rr_waddr4", 16'(rf_waddr), 16'h4);
    chk("rr_wdata4", rf_wdata, 16'hA003);
    step();
    req_valid = '0;
    #1;
    chk("rr_we5", 16'(rf_we), 16'h1);
    chk("rr_waddr5", 16'(rf_waddr), 16'h1);
    chk("rr_busy5", 16'(busy), 16'h1);
    step();
    chk("drain_we", 16'(rf_we), 16'h0);
    chk("drain_busy1", 16'(busy), 16'h1);
    step();
    chk("drain_busy0", 16'(busy), 16'h0);
    // Forwarding: pointer is 1, requester 1 writes addr 5 = BEEF
    set_req(1, 4'd5, 16'hBEEF);
    raddr_a = 4'd5; rf_rdata_a = 16'h0000;
    #1;
    chk("fwd_ready", 16'(req_ready), 16'h2);
    chk("fwd_T", rdata_a, 16'h0000);
    step();
    req_valid = '0;
    #1;
    chk("fwd_we", 16'(rf_we), 16'h1);
    chk("fwd_waddr", 16'(rf_waddr), 16'h5);
    chk("fwd_wdata", rf_wdata, 16'hBEEF);
    chk("fwd_T1", rdata_a, 16'hBEEF);
    step();
    chk("fwd_T2", rdata_a, 16'hBEEF);
    chk("fwd_T2_we", 16'(rf_we), 16'h0);
    chk("fwd_T2_busy", 16'(busy), 16'h1);
    step();
    rf_rdata_a = 16'h1234;
    #1;
    chk("fwd_T3", rdata_a, 16'h1234);
    chk("fwd_T3_busy", 16'(busy), 16'h0);
    // Address 0: pointer is 2, requester 2 writes addr 0
    set_req(2, 4'd0, 16'hFFFF);
    raddr_a = 4'd0; rf_rdata_a = 16'hAAAA;
    #1;
    chk("a0_ready", 16'(req_ready), 16'h4);
    chk("a0_rdata", rdata_a, 16'hAAAA);
    step();
    set_req(2, 4'd9, 16'h0909);
    set_req(3, 4'd3, 16'h3333);
    #1;
    chk("a0_we", 16'(rf_we), 16'h0);
    chk("a0_busy", 16'(busy), 16'h0);
    chk("a0_rdata2", rdata_a, 16'hAAAA);
    chk("a0_ptr_adv", 16'(req_ready), 16'h8);
    step();
    req_valid = '0;
    #1;
    chk("a0_next_we", 16'(rf_we), 16'h1);
    chk("a0_next_waddr", 16'(rf_waddr), 16'h3);
    step(); step();
    // Same-address collision: pointer is 0, requester 0 writes addr 7 twice
    set_req(0, 4'd7, 16'h1111);
    raddr_b = 4'd7; rf_rdata_b = 16'h0055;
    #1;
    chk("col_ready0", 16'(req_ready), 16'h1);
    chk("col_T", rdata_b, 16'h0055);
    step();
    set_req(0, 4'd7, 16'h2222);
    #1;
    chk("col_ready1", 16'(req_ready), 16'h1);
    chk("col_T1", rdata_b, 16'h1111);
    step();
    req_valid = '0;
    #1;
    chk("col_T2", rdata_b, 16'h2222);
    chk("col_wdata", rf_wdata, 16'h2222);
    step();
    chk("col_T3", rdata_b, 16'h2222);
    step();
    chk("col_T4", rdata_b, 16'h0055);
    // Hold: pointer is 1, requesters 0 and 1 valid
    hold = 1'b1;
    set_req(0, 4'hB, 16'h0B0B);
    set_req(1, 4'hA, 16'h0A0A);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 16'(req_ready), 16'h0);
      chk("hold_we", 16'(rf_we), 16'h0);
      step();
    end
    hold = 1'b0;
    #1;
    chk("hold_release", 16'(req_ready), 16'h2);
    step();
    req_valid[1] = 1'b0;
    #1;
    chk("hold_we1", 16'(rf_we), 16'h1);
    chk("hold_waddr1", 16'(rf_waddr), 16'hA);
    chk("hold_wdata1", rf_wdata, 16'h0A0A);
    chk("hold_ready0", 16'(req_ready), 16'h1);
    step();
    for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 16'hC000 + 16'(k));
    #1;
    chk("pre_rst_we", 16'(rf_we), 16'h1);
    chk("pre_rst_waddr", 16'(rf_waddr), 16'hB);
    chk("pre_rst_ready", 16'(req_ready), 16'h2);
    // Reset mid-write
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 16'(rf_we), 16'h0);
    chk("mid_rst_ready", 16'(req_ready), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 16'(req_ready), 16'h1);
    step();
    chk("post_rst_waddr", 16'(rf_waddr), 16'h1);
    chk("post_rst_wdata", rf_wdata, 16'hC000);
    req_valid = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
